// File: rtl/lsu_pkg.sv
// Shared state encoding, RV32I funct3 encodings and request legality helpers
// for the load/store controller.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
           ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 > F3_W;
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-memory port bundle of lsu_ctrl; names are seen from the controller.
// mem_be_o exists only when LSU_BYTE_STROBE_EN is defined.
interface lsu_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_we_i;
  logic [2:0]               req_funct3_i;
  logic [31:0]              req_addr_i;
  logic [31:0]              req_wdata_i;
  logic                     resp_valid_o;
  logic [31:0]              resp_rdata_o;
  logic                     resp_err_o;
  logic [ADDRESS_WIDTH-1:0] mem_a_o;
  logic [31:0]              mem_wd_o;
  logic                     mem_wen_o;
  logic [31:0]              mem_rd_i;
`ifdef LSU_BYTE_STROBE_EN
  logic [3:0]               mem_be_o;
`endif

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rd_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_a_o, mem_wd_o, mem_wen_o
`ifdef LSU_BYTE_STROBE_EN
    , output mem_be_o
`endif
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, mem_rd_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, mem_a_o, mem_wd_o, mem_wen_o
`ifdef LSU_BYTE_STROBE_EN
    , input mem_be_o
`endif
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, store merge into the old word,
// or lane replication plus byte strobes when LSU_BYTE_STROBE_EN is defined.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] write_data
`ifdef LSU_BYTE_STROBE_EN
  , output logic [3:0] write_be
`endif
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = mem_word;
    endcase
  end

`ifdef LSU_BYTE_STROBE_EN
  always_comb begin
    write_data = store_data;
    write_be   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        write_data = {4{store_data[7:0]}};
        write_be   = 4'b0001 << lane;
      end
      2'b01: begin
        write_data = {2{store_data[15:0]}};
        write_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end
`else
  // mem_word is the word captured during READ when merging a sub-word store.
  always_comb begin
    write_data = mem_word;
    case (funct3[1:0])
      2'b00:   write_data[{lane, 3'b000} +: 8]    = store_data[7:0];
      2'b01:   write_data[{lane[1], 4'b0000} +: 16] = store_data[15:0];
      default: write_data = store_data;
    endcase
  end
`endif

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: one outstanding request, load 2 cycles accept-to-resp, RMW for SB/SH.
// req_ready_o only in IDLE; LSU_BYTE_STROBE_EN replaces RMW with byte strobes on mem_be_o.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input logic  clk_i,
  input logic  rst_ni,
  lsu_if.slave bus
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_ctrl: DATA_WIDTH must be 32");
  end

  lsu_state_t               state_q, state_d;
  logic [ADDRESS_WIDTH+1:0] addr_q;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     err_q;
  logic                     accept;
  logic                     bad_req;
  logic [DATA_WIDTH-1:0]    align_word;
  logic [DATA_WIDTH-1:0]    load_data;
  logic [DATA_WIDTH-1:0]    write_data;

  assign accept  = bus.req_valid_i && (state_q == IDLE);
  assign bad_req = is_misaligned(bus.req_funct3_i, bus.req_addr_i[1:0]) ||
                   is_illegal(bus.req_we_i, bus.req_funct3_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          if (bad_req)                        state_d = RESP;
          else if (!bus.req_we_i)             state_d = READ;
`ifdef LSU_BYTE_STROBE_EN
          else                                state_d = WRITE;
`else
          else if (bus.req_funct3_i == F3_W)  state_d = WRITE;
          else                                state_d = READ;
`endif
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

`ifdef LSU_BYTE_STROBE_EN
  assign align_word = bus.mem_rd_i;
`else
  logic [DATA_WIDTH-1:0] word_q;
  assign align_word = (state_q == WRITE) ? word_q : bus.mem_rd_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifndef LSU_BYTE_STROBE_EN
      word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= bus.req_addr_i[ADDRESS_WIDTH+1:0];
        we_q    <= bus.req_we_i;
        f3_q    <= bus.req_funct3_i;
        wdata_q <= bus.req_wdata_i;
      end
      if (accept && bad_req) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
      if (state_q == READ && !we_q) begin
        rdata_q <= load_data;
        err_q   <= 1'b0;
      end
`ifndef LSU_BYTE_STROBE_EN
      if (state_q == READ && we_q) word_q <= bus.mem_rd_i;
`endif
      if (state_q == WRITE) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  lsu_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .mem_word   (align_word),
    .store_data (wdata_q),
    .load_data  (load_data),
    .write_data (write_data)
`ifdef LSU_BYTE_STROBE_EN
    , .write_be (write_be)
`endif
  );

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;
  assign bus.mem_a_o      = addr_q[ADDRESS_WIDTH+1:2];
  assign bus.mem_wen_o    = (state_q == WRITE);
  assign bus.mem_wd_o     = (state_q == WRITE) ? write_data : '0;
`ifdef LSU_BYTE_STROBE_EN
  logic [3:0] write_be;
  assign bus.mem_be_o     = (state_q == WRITE) ? write_be : 4'b0000;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: word memory model, directed plan cases and
// randomized requests against a byte-arithmetic reference model.
module tb_lsu_ctrl;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wen_cnt = 0;

  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

`ifdef LSU_BYTE_STROBE_EN
  localparam int SUB_LAT = 2;
`else
  localparam int SUB_LAT = 3;
`endif

  lsu_if #(.ADDRESS_WIDTH(16)) bus ();

  lsu_ctrl #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  assign bus.mem_rd_i = mem[bus.mem_a_o];

  always @(posedge clk_i) begin
    if (bus.mem_wen_o === 1'b1) begin
      wen_cnt = wen_cnt + 1;
`ifdef LSU_BYTE_STROBE_EN
      for (int b = 0; b < 4; b++)
        if (bus.mem_be_o[b]) mem[bus.mem_a_o][8*b +: 8] = bus.mem_wd_o[8*b +: 8];
`else
      mem[bus.mem_a_o] = bus.mem_wd_o;
`endif
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int  size;
    bit  legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    return !legal || ((addr % size) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
    longint v;
    int     sh;
    sh = 8 * int'(addr % 4);
    v  = longint'(word >> sh);
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: v = longint'(word);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
    longint mask, res;
    int     sh;
    mask = (longint'(1) << (8 * (1 << f3[1:0]))) - 1;
    sh   = 8 * int'(addr % 4);
    res  = (longint'(old) & ~(mask << sh)) | ((longint'(wd) & mask) << sh);
    return res[31:0];
  endfunction

  function automatic int model_idx(input logic [31:0] addr);
    return int'((addr >> 2) & 32'hFFFF);
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic err,
                        output int lat, output int wens, output logic pulse_after,
                        output logic [31:0] held);
    int w0;
    @(negedge clk_i);
    w0 = wen_cnt;
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wd;
    @(negedge clk_i);
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'($urandom);
    bus.req_funct3_i = 3'($urandom);
    bus.req_addr_i   = $urandom;
    bus.req_wdata_i  = $urandom;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      if (bus.resp_valid_o === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk_i);
    end
    rdata = bus.resp_rdata_o;
    err   = bus.resp_err_o;
    @(negedge clk_i);
    pulse_after = bus.resp_valid_o;
    held        = bus.resp_rdata_o;
    wens        = wen_cnt - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.req_ready_o); end
    checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.resp_valid_o); end
    checks++; if (bus.resp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.resp_rdata_o); end
    checks++; if (bus.resp_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.resp_err_o); end
    checks++; if (bus.mem_wen_o !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", bus.mem_wen_o); end
    checks++; if (bus.mem_a_o !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.mem_a_o); end
    checks++; if (bus.mem_wd_o !== 32'h0) begin errors++; $display("FAIL reset_wd got %h want 0", bus.mem_wd_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] adrs [5] = '{32'h41, 32'h41, 32'h42, 32'h42, 32'h40};
    logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
    logic [31:0] rd, held;
    logic        er, pa;
    int          lat, wens;
    mem[16] = 32'h8899AABB;
    ref_mem[16] = 32'h8899AABB;
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], adrs[i], 32'h0, rd, er, lat, wens, pa, held);
      checks++; if (rd !== exps[i]) begin errors++; $display("FAIL load_data[%0d] got %h want %h", i, rd, exps[i]); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err[%0d] got %b want 0", i, er); end
      checks++; if (lat != 2) begin errors++; $display("FAIL load_latency[%0d] got %0d want 2", i, lat); end
      checks++; if (pa !== 1'b0 || held !== exps[i]) begin errors++; $display("FAIL load_pulse_hold[%0d] got valid=%b data=%h want valid=0 data=%h", i, pa, held, exps[i]); end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s  [2] = '{3'd0, 3'd1};
    logic [31:0] adrs [2] = '{32'h43, 32'h40};
    logic [31:0] wds  [2] = '{32'hDEADBEEF, 32'h0000CAFE};
    logic [31:0] exps [2] = '{32'hEF223344, 32'hEF22CAFE};
    logic [31:0] rd, held;
    logic        er, pa;
    int          lat, wens;
    mem[16] = 32'h11223344;
    ref_mem[16] = 32'h11223344;
    for (int i = 0; i < 2; i++) begin
      do_req(1'b1, f3s[i], adrs[i], wds[i], rd, er, lat, wens, pa, held);
      checks++; if (mem[16] !== exps[i]) begin errors++; $display("FAIL store_mem[%0d] got %h want %h", i, mem[16], exps[i]); end
      checks++; if (wens != 1) begin errors++; $display("FAIL store_wen_pulses[%0d] got %0d want 1", i, wens); end
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_resp[%0d] got err=%b data=%h want err=0 data=0", i, er, rd); end
      checks++; if (lat != SUB_LAT) begin errors++; $display("FAIL store_latency[%0d] got %0d want %0d", i, lat, SUB_LAT); end
    end
    ref_mem[16] = exps[1];
  endtask

  task automatic test_errors();
    bit          wes  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s  [3] = '{3'd2, 3'd1, 3'd3};
    logic [31:0] adrs [3] = '{32'h41, 32'h43, 32'h40};
    logic [31:0] rd, held;
    logic        er, pa;
    int          lat, wens;
    mem[16] = 32'h5A5A1234;
    for (int i = 0; i < 3; i++) begin
      do_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, rd, er, lat, wens, pa, held);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_flag[%0d] got %b want 1", i, er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_data[%0d] got %h want 0", i, rd); end
      checks++; if (wens != 0) begin errors++; $display("FAIL err_wen[%0d] got %0d want 0", i, wens); end
      checks++; if (mem[16] !== 32'h5A5A1234) begin errors++; $display("FAIL err_mem[%0d] got %h want 5a5a1234", i, mem[16]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL err_latency[%0d] got %0d want 1", i, lat); end
    end
    ref_mem[16] = 32'h5A5A1234;
  endtask

  task automatic test_reset_mid();
    int w0;
    mem[16] = 32'h11223344;
    ref_mem[16] = 32'h11223344;
    @(negedge clk_i);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'd0;
    bus.req_addr_i   = 32'h41;
    bus.req_wdata_i  = 32'hA5A5A5A5;
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got ready=%b want 0", bus.req_ready_o); end
    w0 = wen_cnt;
    rst_ni = 1'b0;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid_hs got ready=%b valid=%b want 1 0", bus.req_ready_o, bus.resp_valid_o); end
    checks++; if (bus.mem_wen_o !== 1'b0 || bus.mem_a_o !== 16'h0 || bus.mem_wd_o !== 32'h0) begin errors++; $display("FAIL rst_mid_mem got wen=%b a=%h wd=%h want 0 0 0", bus.mem_wen_o, bus.mem_a_o, bus.mem_wd_o); end
    checks++; if (bus.resp_rdata_o !== 32'h0 || bus.resp_err_o !== 1'b0) begin errors++; $display("FAIL rst_mid_resp got data=%h err=%b want 0 0", bus.resp_rdata_o, bus.resp_err_o); end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (wen_cnt != w0) begin errors++; $display("FAIL rst_mid_nowrite got %0d writes want 0", wen_cnt - w0); end
    checks++; if (mem[16] !== 32'h11223344) begin errors++; $display("FAIL rst_mid_memory got %h want 11223344", mem[16]); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", bus.req_ready_o); end
  endtask

  task automatic test_random();
    logic [31:0] rd, held, addr, wd, exp_d;
    logic [2:0]  f3;
    logic        er, pa, exp_e;
    bit          we;
    int          lat, wens, idx, exp_l, exp_w;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int t = 0; t < 80; t++) begin
      we   = 1'($urandom);
      f3   = we ? 3'($urandom_range(0, 3)) : 3'($urandom);
      addr = {14'($urandom), 10'b0, 8'($urandom)};
      wd   = $urandom;
      idx  = model_idx(addr);
      exp_e = model_err(we, f3, addr);
      exp_d = (exp_e || we) ? 32'h0 : model_load(ref_mem[idx], f3, addr);
      exp_l = exp_e ? 1 : (!we ? 2 : (f3 == 3'd2 ? 2 : SUB_LAT));
      exp_w = (exp_e || !we) ? 0 : 1;
      if (!exp_e && we) ref_mem[idx] = model_store(ref_mem[idx], f3, addr, wd);
      do_req(we, f3, addr, wd, rd, er, lat, wens, pa, held);
      checks++; if (rd !== exp_d || er !== exp_e) begin errors++; $display("FAIL rand_resp[%0d] we=%b f3=%0d a=%h got data=%h err=%b want data=%h err=%b", t, we, f3, addr, rd, er, exp_d, exp_e); end
      checks++; if (lat != exp_l) begin errors++; $display("FAIL rand_latency[%0d] got %0d want %0d", t, lat, exp_l); end
      checks++; if (wens != exp_w) begin errors++; $display("FAIL rand_wen[%0d] got %0d want %0d", t, wens, exp_w); end
      checks++; if (mem[idx] !== ref_mem[idx]) begin errors++; $display("FAIL rand_mem[%0d] word %0d got %h want %h", t, idx, mem[idx], ref_mem[idx]); end
      checks++; if (pa !== 1'b0) begin errors++; $display("FAIL rand_single_pulse[%0d] got valid=%b want 0", t, pa); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s  [3] = '{3'd2, 3'd0, 3'd5};
    logic [31:0] adrs [3] = '{32'h80, 32'h85, 32'h8A};
    logic [31:0] exps [3];
    logic [31:0] got [$];
    int          rcyc [$];
    int          idx = 0;
    bit          presented;
    for (int i = 0; i < 3; i++) begin
      mem[32 + i] = $urandom;
      ref_mem[32 + i] = mem[32 + i];
      exps[i] = model_load(ref_mem[model_idx(adrs[i])], f3s[i], adrs[i]);
    end
    @(negedge clk_i);
    for (int c = 0; c < 30; c++) begin
      if (idx < 3) begin
        bus.req_valid_i  = 1'b1;
        bus.req_we_i     = 1'b0;
        bus.req_funct3_i = f3s[idx];
        bus.req_addr_i   = adrs[idx];
      end else begin
        bus.req_valid_i = 1'b0;
      end
      presented = (idx < 3) && (bus.req_ready_o === 1'b1);
      @(negedge clk_i);
      if (presented) idx++;
      if (bus.resp_valid_o === 1'b1) begin
        rcyc.push_back(c);
        got.push_back(bus.resp_rdata_o);
      end
    end
    bus.req_valid_i = 1'b0;
    checks++; if (rcyc.size() != 3) begin errors++; $display("FAIL b2b_count got %0d want 3", rcyc.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++; if (got[i] !== exps[i]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got[i], exps[i]); end
    end
    for (int i = 1; i < rcyc.size(); i++) begin
      checks++; if (rcyc[i] - rcyc[i-1] != 3) begin errors++; $display("FAIL b2b_spacing[%0d] got %0d want 3", i, rcyc[i] - rcyc[i-1]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bus.req_valid_i  = 1'b0;
    bus.req_we_i     = 1'b0;
    bus.req_funct3_i = 3'd0;
    bus.req_addr_i   = 32'h0;
    bus.req_wdata_i  = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
